// File: rtl/control_pkg.sv
// Control-path types shared across the core.
//   e_imem_state : boot/sequencing state of the instruction memory responder
package control_pkg;
    typedef enum logic [1:0] {
        IMEM_LOAD    = 2'd0,
        IMEM_TRIGGER = 2'd1,
        IMEM_RUN     = 2'd2
    } e_imem_state;
endpackage

// File: rtl/instructions_pkg.sv
// Instruction-format constants shared by the fetch path.
//   XLEN      : address/data width of the core
//   ILEN      : instruction word width
//   NOP_INSTR : canonical NOP (addi x0, x0, 0), returned on faulted fetches
package instructions_pkg;
    localparam int          XLEN      = 32;
    localparam int          ILEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/inst_mem_array.sv
// Single-port instruction RAM, DEPTH_WORDS x 32, synchronous read.
// The storage array itself is never reset so contents survive a core reset;
// only the read-data register is reset.
// Ports:
//   clk   : clock
//   rst   : async active-high reset (read-data register only)
//   we    : write enable
//   re    : read enable; rdata updates only on a read and holds otherwise
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : registered read data
module inst_mem_array #(
    parameter int  DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: owns the instruction RAM, its boot-load port,
// the boot FSM that fires the first fetch, and a LATENCY-deep response
// pipeline with fault checking. No backpressure toward fetch.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IMEM_LOAD    | boot loader owns the RAM; fetch requests are rejected
// IMEM_TRIGGER | one cycle: first_fetch_trigger high
// IMEM_RUN     | fetch requests served; load writes rejected
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   inst_request        : fetch request valid
//   inst_addr           : byte address of the fetch
//   flush               : kill in-flight responses (same-cycle request kept)
//   load_we/addr/data   : boot-load write port (LOAD only)
//   load_done           : loading complete, start the core
//   first_fetch_trigger : one-cycle pulse enabling fetch
//   inst_valid          : response valid
//   inst_data           : instruction word (NOP on a fault)
//   inst_fault          : response is misaligned or out of range
//   resp_addr           : byte address of the response
//   load_err            : sticky protocol-violation flag
//   fetch_count         : saturating count of accepted requests
module inst_mem_responder
    import control_pkg::*;
#(
    parameter int  XLEN        = instructions_pkg::XLEN,
    parameter int  DEPTH_WORDS = 1024,
    parameter int  LATENCY     = 1,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_request,
    input  logic [XLEN-1:0] inst_addr,
    input  logic            flush,
    input  logic            load_we,
    input  logic [AW-1:0]   load_addr,
    input  logic [31:0]     load_data,
    input  logic            load_done,
    output logic            first_fetch_trigger,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic            inst_fault,
    output logic [XLEN-1:0] resp_addr,
    output logic            load_err,
    output logic [31:0]     fetch_count
);

    e_imem_state state_q, state_d;

    logic            accept;
    logic            misaligned;
    logic            out_of_range;
    logic            fault;
    logic            ram_we;
    logic            ram_re;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_rdata;

    logic            s1_valid;
    logic [XLEN-1:0] s1_addr;
    logic            s1_fault;
    logic [31:0]     s1_data;

    // ------------------------------------------------------------------
    // Boot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IMEM_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        first_fetch_trigger = 1'b0;
        case (state_q)
            IMEM_LOAD: begin
                if (load_done) begin
                    state_d = IMEM_TRIGGER;
                end
            end
            IMEM_TRIGGER: begin
                first_fetch_trigger = 1'b1;
                state_d             = IMEM_RUN;
            end
            IMEM_RUN: begin
                state_d = IMEM_RUN;
            end
            default: begin
                state_d = IMEM_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request acceptance and fault check
    // ------------------------------------------------------------------
    assign accept     = inst_request && (state_q == IMEM_RUN);
    assign misaligned = |inst_addr[1:0];
    // Full-width word index compare so high addresses cannot alias low words.
    assign out_of_range = inst_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS);
    assign fault        = misaligned || out_of_range;

    // ------------------------------------------------------------------
    // RAM port mux: loader in LOAD, fetch otherwise
    // ------------------------------------------------------------------
    assign ram_we   = load_we && (state_q == IMEM_LOAD);
    assign ram_re   = accept && !fault;
    assign ram_addr = (state_q == IMEM_LOAD) ? load_addr : inst_addr[AW+1:2];

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Sticky error flag and saturating fetch counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err <= 1'b0;
        end else if ((inst_request && (state_q != IMEM_RUN)) ||
                     (load_we && (state_q != IMEM_LOAD))) begin
            load_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage 1: RAM read cycle. Address/fault only load on accept
    // so that idle cycles hold the last response fields.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_fault <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= inst_addr;
                s1_fault <= fault;
            end
        end
    end

    // A faulted request never reads the RAM, so the stale rdata is masked.
    assign s1_data = s1_fault ? instructions_pkg::NOP_INSTR : ram_rdata;

    // ------------------------------------------------------------------
    // Stages 2..LATENCY: pure register delay. Flush clears every stage
    // that is still in flight; the stage-1 load of the same cycle is kept.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_lat1
            // Nothing is in flight behind the output register.
            logic unused_flush;
            assign unused_flush = flush;

            assign inst_valid = s1_valid;
            assign inst_data  = s1_data;
            assign inst_fault = s1_fault;
            assign resp_addr  = s1_addr;
        end else begin : g_latn
            logic [LATENCY:2] lat_valid;
            logic [XLEN-1:0]  lat_addr  [2:LATENCY];
            logic             lat_fault [2:LATENCY];
            logic [31:0]      lat_data  [2:LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lat_valid <= '0;
                    for (int k = 2; k <= LATENCY; k++) begin
                        lat_addr[k]  <= '0;
                        lat_fault[k] <= 1'b0;
                        lat_data[k]  <= '0;
                    end
                end else begin
                    lat_valid[2] <= s1_valid && !flush;
                    if (s1_valid) begin
                        lat_addr[2]  <= s1_addr;
                        lat_fault[2] <= s1_fault;
                        lat_data[2]  <= s1_data;
                    end
                    for (int k = 3; k <= LATENCY; k++) begin
                        lat_valid[k] <= lat_valid[k-1] && !flush;
                        if (lat_valid[k-1]) begin
                            lat_addr[k]  <= lat_addr[k-1];
                            lat_fault[k] <= lat_fault[k-1];
                            lat_data[k]  <= lat_data[k-1];
                        end
                    end
                end
            end

            assign inst_valid = lat_valid[LATENCY];
            assign inst_data  = lat_data[LATENCY];
            assign inst_fault = lat_fault[LATENCY];
            assign resp_addr  = lat_addr[LATENCY];
        end
    endgenerate

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            inst_request;
    logic [XLEN-1:0] inst_addr;
    logic            flush;
    logic            load_we;
    logic [AW-1:0]   load_addr;
    logic [31:0]     load_data;
    logic            load_done;

    logic            trig2, valid2, fault2, lerr2;
    logic [31:0]     data2, cnt2;
    logic [XLEN-1:0] raddr2;
    logic            trig3, valid3, fault3, lerr3;
    logic [31:0]     data3, cnt3;
    logic [XLEN-1:0] raddr3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inst_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
        .clk                 (clk),
        .rst                 (rst),
        .inst_request        (inst_request),
        .inst_addr           (inst_addr),
        .flush               (flush),
        .load_we             (load_we),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .load_done           (load_done),
        .first_fetch_trigger (trig2),
        .inst_valid          (valid2),
        .inst_data           (data2),
        .inst_fault          (fault2),
        .resp_addr           (raddr2),
        .load_err            (lerr2),
        .fetch_count         (cnt2)
    );

    inst_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
        .clk                 (clk),
        .rst                 (rst),
        .inst_request        (inst_request),
        .inst_addr           (inst_addr),
        .flush               (flush),
        .load_we             (load_we),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .load_done           (load_done),
        .first_fetch_trigger (trig3),
        .inst_valid          (valid3),
        .inst_data           (data3),
        .inst_fault          (fault3),
        .resp_addr           (raddr3),
        .load_err            (lerr3),
        .fetch_count         (cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated fetch; LATENCY=2 response checked after 2 edges, LATENCY=3 after 3.
    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_d, input logic exp_f);
        inst_request = 1'b1;
        inst_addr    = addr;
        tick();
        inst_request = 1'b0;
        inst_addr    = '0;
        tick();
        chk({tag, "_v2"}, 32'(valid2), 32'd1);
        chk({tag, "_d2"}, data2, exp_d);
        chk({tag, "_f2"}, 32'(fault2), 32'(exp_f));
        chk({tag, "_a2"}, raddr2, addr);
        tick();
        chk({tag, "_v3"}, 32'(valid3), 32'd1);
        chk({tag, "_d3"}, data3, exp_d);
        chk({tag, "_f3"}, 32'(fault3), 32'(exp_f));
        chk({tag, "_a3"}, raddr3, addr);
    endtask

    initial begin
        rst          = 1'b1;
        inst_request = 1'b0;
        inst_addr    = '0;
        flush        = 1'b0;
        load_we      = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        load_done    = 1'b0;

        // Reset state
        tick();
        chk("rst_valid", 32'(valid2), 32'd0);
        chk("rst_trig",  32'(trig2),  32'd0);
        chk("rst_fault", 32'(fault2), 32'd0);
        chk("rst_lerr",  32'(lerr2),  32'd0);
        chk("rst_data",  data2,       32'd0);
        chk("rst_raddr", raddr2,      32'd0);
        chk("rst_cnt",   cnt2,        32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Boot load of words 0..3, then trigger
        for (int i = 0; i < 4; i++) begin
            load_we   = 1'b1;
            load_addr = AW'(i);
            load_data = 32'(i + 1) * 32'h11;
            tick();
        end
        load_we   = 1'b0;
        load_done = 1'b1;
        chk("pre_trig", 32'(trig2), 32'd0);
        tick();
        load_done = 1'b0;
        chk("trig_on2", 32'(trig2), 32'd1);
        chk("trig_on3", 32'(trig3), 32'd1);
        tick();
        chk("trig_off", 32'(trig2), 32'd0);
        tick();
        chk("trig_off2", 32'(trig2), 32'd0);
        chk("lerr_clean", 32'(lerr2), 32'd0);

        // Back-to-back stream 0x0,0x4,0x8,0xC
        for (int c = 0; c < 6; c++) begin
            inst_request = (c < 4);
            inst_addr    = (c < 4) ? 32'(4 * c) : 32'd0;
            tick();
            chk($sformatf("b2b_v2_%0d", c), 32'(valid2), ((c >= 1) && (c <= 4)) ? 32'd1 : 32'd0);
            if ((c >= 1) && (c <= 4)) begin
                chk($sformatf("b2b_d2_%0d", c), data2, 32'(c) * 32'h11);
                chk($sformatf("b2b_a2_%0d", c), raddr2, 32'(4 * (c - 1)));
            end
            chk($sformatf("b2b_v3_%0d", c), 32'(valid3), ((c >= 2) && (c <= 5)) ? 32'd1 : 32'd0);
            if ((c >= 2) && (c <= 5)) begin
                chk($sformatf("b2b_d3_%0d", c), data3, 32'(c - 1) * 32'h11);
            end
        end
        chk("b2b_cnt", cnt2, 32'd4);

        // Faults: misaligned, just past the end, high address (no aliasing)
        read_chk("mis",  32'h0000_0006, 32'h0000_0013, 1'b1);
        read_chk("oor",  32'h0000_1000, 32'h0000_0013, 1'b1);
        read_chk("high", 32'h8000_0000, 32'h0000_0013, 1'b1);
        read_chk("ok8",  32'h0000_0008, 32'h0000_0033, 1'b0);
        chk("fault_cnt", cnt3, 32'd8);

        // Flush: 0x0, 0x4, then flush together with 0xC
        inst_request = 1'b1;
        inst_addr    = 32'h0;
        tick();
        inst_addr    = 32'h4;
        tick();
        chk("fl_keep_v2", 32'(valid2), 32'd1);
        chk("fl_keep_d2", data2, 32'h11);
        chk("fl_pre_v3", 32'(valid3), 32'd0);
        inst_addr = 32'hC;
        flush     = 1'b1;
        tick();
        inst_request = 1'b0;
        inst_addr    = '0;
        flush        = 1'b0;
        chk("fl_kill0_v3", 32'(valid3), 32'd0);
        chk("fl_kill4_v2", 32'(valid2), 32'd0);
        tick();
        chk("fl_kill4_v3", 32'(valid3), 32'd0);
        chk("fl_c_v2", 32'(valid2), 32'd1);
        chk("fl_c_d2", data2, 32'h44);
        tick();
        chk("fl_c_v3", 32'(valid3), 32'd1);
        chk("fl_c_d3", data3, 32'h44);
        chk("fl_c_a3", raddr3, 32'hC);
        tick();
        chk("fl_after_v3", 32'(valid3), 32'd0);
        chk("fl_cnt", cnt3, 32'd11);

        // Load write while running is ignored and flagged
        chk("lerr_before", 32'(lerr3), 32'd0);
        load_we   = 1'b1;
        load_addr = '0;
        load_data = 32'hFF;
        tick();
        load_we = 1'b0;
        chk("lerr_we_run", 32'(lerr3), 32'd1);
        read_chk("nowrite", 32'h0, 32'h11, 1'b0);
        chk("lerr_sticky", 32'(lerr2), 32'd1);
        chk("run_cnt", cnt3, 32'd12);

        // Reset with two requests in flight
        inst_request = 1'b1;
        inst_addr    = 32'h0;
        tick();
        inst_addr = 32'h4;
        tick();
        chk("pre_rst_v2", 32'(valid2), 32'd1);
        inst_request = 1'b0;
        inst_addr    = '0;
        rst          = 1'b1;
        #1;
        chk("arst_v2",    32'(valid2), 32'd0);
        chk("arst_v3",    32'(valid3), 32'd0);
        chk("arst_d2",    data2,       32'd0);
        chk("arst_a2",    raddr2,      32'd0);
        chk("arst_lerr",  32'(lerr2),  32'd0);
        chk("arst_cnt",   cnt3,        32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stale_v2_%0d", c), 32'(valid2), 32'd0);
            chk($sformatf("stale_v3_%0d", c), 32'(valid3), 32'd0);
        end

        // Request while loading: dropped and flagged
        inst_request = 1'b1;
        inst_addr    = 32'h4;
        tick();
        inst_request = 1'b0;
        inst_addr    = '0;
        chk("load_req_lerr", 32'(lerr3), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("load_req_v3_%0d", c), 32'(valid3), 32'd0);
        end
        chk("load_req_cnt", cnt3, 32'd0);

        // Restart: write coincident with load_done still lands
        load_we   = 1'b1;
        load_addr = AW'(5);
        load_data = 32'h55;
        load_done = 1'b1;
        tick();
        load_we   = 1'b0;
        load_done = 1'b0;
        chk("re_trig", 32'(trig3), 32'd1);
        tick();
        chk("re_trig_off", 32'(trig3), 32'd0);
        read_chk("retain", 32'h4,  32'h22, 1'b0);
        read_chk("wdone",  32'h14, 32'h55, 1'b0);
        chk("re_cnt", cnt3, 32'd2);

        // Saturation of fetch_count on the LATENCY=2 instance
        force u_lat2.fetch_count = 32'hFFFF_FFFE;
        #2;
        release u_lat2.fetch_count;
        inst_request = 1'b1;
        inst_addr    = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("sat_%0d", c), cnt2, 32'hFFFF_FFFF);
        end
        inst_request = 1'b0;
        chk("sat_other", cnt3, 32'd5);
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Responder side of the instruction-fetch interface: accepts one fetch request per cycle (`inst_request`/`inst_addr`) and returns the addressed 32-bit instruction after a fixed, parameterised latency. It owns the instruction memory array, a boot-load port for filling it, and the boot FSM that issues the one-cycle `first_fetch_trigger` that starts the fetch stage. It sits between the core's fetch stage and the instruction storage, with no backpressure toward fetch.

## Interface
Parameters:
- `XLEN`, 32, address and data width; taken from `instructions_pkg`.
- `DEPTH_WORDS`, 1024, memory depth in 32-bit words; power of two, at least 4.
- `LATENCY`, 1, request-to-response delay in cycles; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `inst_request`  in  1  fetch request valid this cycle.
- `inst_addr`  in  XLEN  byte address of the requested instruction.
- `flush`  in  1  kill all in-flight responses (branch or jump redirect).
- `load_we`  in  1  boot-load write strobe.
- `load_addr`  in  log2(DEPTH_WORDS)  boot-load word index.
- `load_data`  in  32  boot-load instruction word.
- `load_done`  in  1  loading complete; starts the core.
- `first_fetch_trigger`  out  1  one-cycle pulse that enables fetch.
- `inst_valid`  out  1  response valid.
- `inst_data`  out  32  instruction word.
- `inst_fault`  out  1  the response is a fault (misaligned or out of range).
- `resp_addr`  out  XLEN  byte address associated with the response.
- `load_err`  out  1  sticky flag for a protocol violation.
- `fetch_count`  out  32  saturating count of accepted requests.

## Operation
- Boot FSM has three states: LOAD, TRIGGER, RUN.
  - LOAD: `load_we` writes `load_data` to `mem[load_addr]`.
  - LOAD -> TRIGGER when `load_done`=1. If `load_we` and `load_done` are high in the same cycle, the write is still performed.
  - TRIGGER: `first_fetch_trigger`=1 for exactly one cycle, then RUN unconditionally.
  - RUN persists until reset.
- A request is accepted only when state is RUN and `inst_request`=1.
  - Each accepted request increments `fetch_count`, which saturates at 0xFFFF_FFFF.
- Requests outside RUN are dropped with no response and set `load_err`.
- `load_we` outside LOAD is ignored (no write) and sets `load_err`.
- `load_err` clears only on reset.
- Fault checks on each accepted request:
  - Misaligned: `inst_addr[1:0]` != 0.
  - Out of range: `inst_addr[XLEN-1:2]` >= `DEPTH_WORDS`. The upper address bits must be compared in full, never truncated.
  - A fault response has `inst_fault`=1, `inst_data`=NOP (32'h0000_0013), and no memory read.
- Flush:
  - Clears the valid bit of every in-flight request. A response that would have appeared in a later cycle does not appear.
  - A request presented in the same cycle as `flush` is accepted, because the redirect address arrives with the flush.
  - A response already on the outputs in the flush cycle is not retracted.
- Responses return strictly in request order. Memory contents are not reset.

## Timing
- A request accepted at edge N produces `inst_valid`=1 in the cycle following edge N+LATENCY-1. With LATENCY=1, data is registered and visible in the cycle after the request.
- `resp_addr` equals the request's `inst_addr`.
- Throughput is one response per cycle. A back-to-back request stream yields back-to-back valid responses.
- Memory read is synchronous, in pipeline stage 1. Stages 2..LATENCY are register delay only.
- `first_fetch_trigger` is high in the cycle after the edge that samples `load_done`=1.
- Reset values:
  - state = LOAD.
  - `first_fetch_trigger`, `inst_valid`, `inst_fault`, `load_err` = 0.
  - `inst_data`, `resp_addr`, `fetch_count` = 0.
- Reset during RUN: in-flight responses are lost, the FSM returns to LOAD, and memory contents are retained.
- Outputs when `inst_valid`=0: `inst_data`, `resp_addr` and `inst_fault` hold their last values and must not be interpreted.

## Structure
- `instructions_pkg`: add constant `NOP_INSTR` = 32'h0000_0013.
- `control_pkg`: add typedef `e_imem_state` {IMEM_LOAD, IMEM_TRIGGER, IMEM_RUN}.
- Sub-module `inst_mem_array`: single-port synchronous-read RAM, DEPTH_WORDS x 32. Write port is used in LOAD, read port in RUN. The top level muxes the two.
- The top level holds the FSM, fault check, LATENCY-stage valid/addr/fault/data pipeline, counter and sticky flag.

## Test plan
- Load 4 words at indices 0..3 (0x11, 0x22, 0x33, 0x44), pulse `load_done` -> exactly one `first_fetch_trigger` pulse. Then requests at 0x0, 0x4, 0x8, 0xC back-to-back with LATENCY=2 -> `inst_valid` for 4 consecutive cycles starting 2 cycles after the first request, data 0x11..0x44 in order, `fetch_count`=4.
- Request 0x6 -> `inst_fault`=1, data 0x13. Request 4*DEPTH_WORDS (0x1000) -> `inst_fault`=1. Request 0x8000_0000 -> `inst_fault`=1, with no aliasing to word 0.
- LATENCY=3: requests 0x0, 0x4, then `flush` together with a request to 0xC -> only the 0xC response appears (data 0x44); the responses for 0x0 and 0x4 never appear.
- Request during LOAD -> no response, `load_err`=1. `load_we` in RUN to index 0 with 0xFF -> a later read of 0x0 still returns 0x11, and `load_err` stays 1.
- Assert `rst` mid-stream with 2 requests in flight -> outputs return to reset values immediately, with no stale response afterward. Reload with only `load_done` -> a read of 0x4 returns the retained 0x22.
- Preload `fetch_count` near saturation (force 0xFFFF_FFFE), then 3 requests -> the count stays at 0xFFFF_FFFF.
